uart_rx: RTL

- UART receive stage that directly consumes the one-cycle `baud_en` sample-tick produced by the baud generator.
- The tick runs at 16x the bit rate.
- Synchronises the asynchronous serial input, detects start bits, and samples each bit at its centre.
- Assembles LSB-first frames (start, DATA_WIDTH data bits, optional parity, one stop bit) and presents bytes on a valid/ready interface to the UART core.

---
 rtl/uart_rx.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// UART receiver: 2-flop input synchroniser, 16x-tick centre sampling, LSB-first framing, valid/ready output.
// Optional parity bit checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_ODD = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  baud_en_i,
    input  logic                  rx_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  busy_o,
    output logic                  frame_err_o,
    output logic                  parity_err_o,
    output logic                  overrun_o
);

    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int IDX_W = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_WIDTH - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
    localparam logic             PAR_ODD_BIT = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3
`ifdef UART_RX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } state_t;

`ifdef UART_RX_PARITY_EN
    localparam state_t ST_AFTER_DATA = ST_PARITY;

    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] d, input logic odd);
        return (^d) ^ odd;
    endfunction
`else
    localparam state_t ST_AFTER_DATA = ST_STOP;
`endif

    state_t                state_r, state_next;
    logic [CNT_W-1:0]      cnt_r, cnt_next;
    logic [IDX_W-1:0]      idx_r, idx_next;
    logic [DATA_WIDTH-1:0] shift_r, shift_next;
    logic [1:0]            rx_sync_r;
    logic                  rx_s;
    logic [DATA_WIDTH-1:0] data_r;
    logic                  valid_r, busy_r, frame_err_r, overrun_r;
    logic                  stop_sample_s, load_s, overrun_s, frame_err_s;

    assign rx_s = rx_sync_r[1];

    // Two-flop synchroniser for the asynchronous line, idles high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], rx_i};
        end
    end

    // FSM state, sample counter, bit index and shift register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shift_r <= '0;
        end else begin
            state_r <= state_next;
            cnt_r   <= cnt_next;
            idx_r   <= idx_next;
            shift_r <= shift_next;
        end
    end

    // Next-state logic; everything holds between baud ticks.
    always_comb begin
        state_next = state_r;
        cnt_next   = cnt_r;
        idx_next   = idx_r;
        shift_next = shift_r;
        if (baud_en_i) begin
            case (state_r)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_next = ST_START;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = '0;
                    end
                end
                ST_START: begin
                    if (cnt_r == CNT_MID) begin
                        cnt_next = '0;
                        if (!rx_s) begin
                            state_next = ST_DATA;
                            idx_next   = '0;
                        end else begin
                            state_next = ST_IDLE;
                        end
                    end else begin
                        cnt_next = cnt_r + CNT_ONE;
                    end
                end
                ST_DATA: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next   = '0;
                        shift_next = {rx_s, shift_r[DATA_WIDTH-1:1]};
                        idx_next   = idx_r + IDX_ONE;
                        if (idx_r == IDX_LAST) begin
                            state_next = ST_AFTER_DATA;
                        end else begin
                            state_next = ST_DATA;
                        end
                    end else begin
                        cnt_next = cnt_r + CNT_ONE;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_STOP;
                    end else begin
                        cnt_next = cnt_r + CNT_ONE;
                    end
                end
`endif
                ST_STOP: begin
                    if (cnt_r == CNT_LAST) begin
                        cnt_next   = '0;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                end
            endcase
        end else begin
            state_next = state_r;
        end
    end

    // Stop-bit decisions: deliver, drop with overrun, or flag a framing error.
    always_comb begin
        load_s      = 1'b0;
        overrun_s   = 1'b0;
        frame_err_s = 1'b0;
        if (baud_en_i && (state_r == ST_STOP) && (cnt_r == CNT_LAST)) begin
            stop_sample_s = 1'b1;
        end else begin
            stop_sample_s = 1'b0;
        end
        if (stop_sample_s) begin
            if (rx_s) begin
                if (!valid_r || ready_i) begin
                    load_s = 1'b1;
                end else begin
                    overrun_s = 1'b1;
                end
            end else begin
                frame_err_s = 1'b1;
            end
        end else begin
            load_s = 1'b0;
        end
    end

    // Registered outputs and the valid/ready handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_r      <= '0;
            valid_r     <= 1'b0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            busy_r      <= (state_next != ST_IDLE);
            frame_err_r <= frame_err_s;
            overrun_r   <= overrun_s;
            if (load_s) begin
                data_r  <= shift_r;
                valid_r <= 1'b1;
            end else if (ready_i) begin
                valid_r <= 1'b0;
            end else begin
                valid_r <= valid_r;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_bit_r, parity_err_r;

    // Capture the parity bit and compare it when the stop bit is sampled.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            parity_bit_r <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            if (baud_en_i && (state_r == ST_PARITY) && (cnt_r == CNT_LAST)) begin
                parity_bit_r <= rx_s;
            end else begin
                parity_bit_r <= parity_bit_r;
            end
            parity_err_r <= stop_sample_s && (calc_parity(shift_r, PAR_ODD_BIT) != parity_bit_r);
        end
    end

    assign parity_err_o = parity_err_r;
`else
    assign parity_err_o = 1'b0 & PAR_ODD_BIT;
`endif

    assign data_o      = data_r;
    assign valid_o     = valid_r;
    assign busy_o      = busy_r;
    assign frame_err_o = frame_err_r;
    assign overrun_o   = overrun_r;

endmodule
